// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// the reset PC and the fetch FSM state encoding.
package fetch_pkg;

  localparam int          ADDR_W_DEF   = 16;
  localparam int          INSTR_W_DEF  = 16;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter register: a load (branch/redirect) takes priority
// over the modulo-2^ADDR_W increment; synchronous reset to RESET_PC.
module program_counter
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues word reads over req/ack, buffers one instruction
// for decode over valid/ready, and squashes wrong-path fetches on redirects.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               redirect_pend_q, redirect_pend_d;
  logic [ADDR_W-1:0]  redirect_tgt_q, redirect_tgt_d;

  logic [ADDR_W-1:0]  pc;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_val;
  logic               pc_inc;
  logic               req_c;
  logic               valid_c;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load_en  (pc_load),
    .load_val (pc_load_val),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    redirect_pend_d = redirect_pend_q;
    redirect_tgt_d  = redirect_tgt_q;
    pc_load         = 1'b0;
    pc_load_val     = branch_target;
    pc_inc          = 1'b0;
    req_c           = 1'b0;
    valid_c         = 1'b0;

    case (state_q)
      REQ: begin
        req_c = 1'b1;
        if (mem_ack) begin
          if (branch_taken) begin
            pc_load = 1'b1;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = pc;
            pc_inc     = 1'b1;
            state_d    = HOLD;
          end
        end else if (branch_taken) begin
          // The read cannot be withdrawn, so park the target until it completes.
          redirect_pend_d = 1'b1;
          redirect_tgt_d  = branch_target;
          state_d         = FLUSH;
        end
      end

      FLUSH: begin
        req_c = 1'b1;
        if (branch_taken) begin
          redirect_tgt_d = branch_target;
        end
        if (mem_ack) begin
          // A redirect arriving with the ack is the most recent one and wins.
          pc_load         = redirect_pend_q | branch_taken;
          pc_load_val     = branch_taken ? branch_target : redirect_tgt_q;
          redirect_pend_d = 1'b0;
          state_d         = REQ;
        end
      end

      HOLD: begin
        valid_c = !branch_taken;
        if (branch_taken) begin
          pc_load = 1'b1;
          state_d = REQ;
        end else if (instr_ready) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= REQ;
      instr_q         <= '0;
      instr_pc_q      <= '0;
      redirect_pend_q <= 1'b0;
      redirect_tgt_q  <= '0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      instr_pc_q      <= instr_pc_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_tgt_q  <= redirect_tgt_d;
    end
  end

  // Handshake outputs are forced low during reset so an in-flight read is abandoned.
  assign mem_req     = req_c & !rst;
  assign mem_addr    = pc;
  assign instr_valid = valid_c & !rst;
  assign instr_out   = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: stimulus pushes expected
// (pc, instr) pairs, a monitor pops and compares on every accepted instruction.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;

  int tests    = 0;
  int fails    = 0;
  int acc_cnt  = 0;
  int lat      = 1;
  int wait_cnt = 0;
  logic prev_acc = 1'b0;
  logic [31:0] exp_q[$];

  instruction_fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: acks the lat-th cycle of a request with 0x1000 + address.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt + 1 >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'h1000 + mem_addr;
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    #1;
    if (rst) begin
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) check("valid_low_after_accept", 16'(instr_valid), 16'h0);
      prev_acc = instr_valid && instr_ready;
      if (instr_valid && instr_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_accept: got pc %h instr %h, expected no instruction", instr_pc, instr_out);
        end else begin
          e = exp_q.pop_front();
          check("accept_pc", instr_pc, e[31:16]);
          check("accept_instr", instr_out, e[15:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 30) begin
      step();
      n++;
    end
    tests++;
    if (!instr_valid) begin
      fails++;
      $display("FAIL wait_valid_timeout: got instr_valid 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic accept_one(input logic [15:0] pc, input logic [15:0] ins);
    wait_valid();
    exp_q.push_back({pc, ins});
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  initial begin
    int n;
    // Reset and streaming fetch with single-cycle memory
    instr_ready = 1'b1;
    step();
    check("rst_mem_req", 16'(mem_req), 16'h0);
    check("rst_valid", 16'(instr_valid), 16'h0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_mem_req", 16'(mem_req), 16'h1);
    check("post_rst_addr", mem_addr, 16'h0000);
    for (int i = 0; i < 4; i++) exp_q.push_back({16'(i), 16'(16'h1000 + i)});
    n = 0;
    while (acc_cnt < 4 && n < 40) begin
      step();
      n++;
    end
    check("stream_accepts", 16'(acc_cnt), 16'd4);
    instr_ready = 1'b0;

    // Consumer stall in HOLD
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_instr", instr_out, 16'h1004);
      check("stall_pc", instr_pc, 16'h0004);
      check("stall_mem_req", 16'(mem_req), 16'h0);
      step();
    end
    accept_one(16'h0004, 16'h1004);
    check("after_stall_req", 16'(mem_req), 16'h1);
    check("after_stall_addr", mem_addr, 16'h0005);

    // Branch in HOLD beats instr_ready
    wait_valid();
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    instr_ready   = 1'b1;
    #1;
    check("hold_branch_valid", 16'(instr_valid), 16'h0);
    step();
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    check("hold_branch_addr", mem_addr, 16'h0040);
    accept_one(16'h0040, 16'h1040);

    // Redirect during a slow read of 0x0005, overwritten while flushing
    wait_valid();
    lat           = 4;
    branch_taken  = 1'b1;
    branch_target = 16'h0005;
    step();
    branch_taken = 1'b0;
    check("slow_req_addr", mem_addr, 16'h0005);
    branch_taken  = 1'b1;
    branch_target = 16'h0070;
    step();
    branch_taken = 1'b0;
    check("flush_addr_1", mem_addr, 16'h0005);
    check("flush_req_1", 16'(mem_req), 16'h1);
    check("flush_valid_1", 16'(instr_valid), 16'h0);
    step();
    branch_taken  = 1'b1;
    branch_target = 16'h0080;
    check("flush_addr_2", mem_addr, 16'h0005);
    check("flush_valid_2", 16'(instr_valid), 16'h0);
    step();
    branch_taken = 1'b0;
    check("flush_addr_3", mem_addr, 16'h0005);
    check("flush_req_3", 16'(mem_req), 16'h1);
    check("flush_valid_3", 16'(instr_valid), 16'h0);
    step();
    check("redirect_addr", mem_addr, 16'h0080);
    lat = 1;
    accept_one(16'h0080, 16'h1080);

    // PC wrap at 0xFFFF
    wait_valid();
    branch_taken  = 1'b1;
    branch_target = 16'hFFFF;
    step();
    branch_taken = 1'b0;
    check("wrap_req_addr", mem_addr, 16'hFFFF);
    accept_one(16'hFFFF, 16'h0FFF);
    check("wrap_next_addr", mem_addr, 16'h0000);

    // Branch coinciding with ack in REQ: data dropped
    branch_taken  = 1'b1;
    branch_target = 16'h0020;
    step();
    branch_taken = 1'b0;
    check("req_ack_branch_addr", mem_addr, 16'h0020);
    check("req_ack_branch_valid", 16'(instr_valid), 16'h0);
    accept_one(16'h0020, 16'h1020);

    // Reset during a pending read
    lat = 4;
    rst = 1'b1;
    #1;
    check("rst_pend_mem_req", 16'(mem_req), 16'h0);
    check("rst_pend_valid", 16'(instr_valid), 16'h0);
    step();
    rst = 1'b0;
    lat = 1;
    #1;
    check("rst_pend_release_req", 16'(mem_req), 16'h1);
    check("rst_pend_release_addr", mem_addr, 16'h0000);
    accept_one(16'h0000, 16'h1000);

    // Reset while holding an instruction
    wait_valid();
    rst = 1'b1;
    #1;
    check("rst_hold_valid", 16'(instr_valid), 16'h0);
    check("rst_hold_mem_req", 16'(mem_req), 16'h0);
    step();
    rst = 1'b0;
    #1;
    check("rst_hold_release_addr", mem_addr, 16'h0000);
    check("rst_hold_release_valid", 16'(instr_valid), 16'h0);
    accept_one(16'h0000, 16'h1000);

    repeat (3) step();
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the instruction path.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Delivers each fetched 16-bit instruction, with its PC, to the instruction register/decode stage over a valid/ready handshake.
- Accepts taken-branch redirects from execute and squashes wrong-path fetches, including a memory read already in flight.

Parameters:
- ADDR_W, 16, width of PC and memory word address.
- INSTR_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  word address; stable while mem_req is high and mem_ack is low.
- mem_ack  input  1  read complete; mem_rdata valid in the same cycle.
- mem_rdata  input  INSTR_W  read data.
- instr_out  output  INSTR_W  fetched instruction, to the instruction register.
- instr_pc  output  ADDR_W  address of instr_out.
- instr_valid  output  1  instr_out/instr_pc valid.
- instr_ready  input  1  consumer accepts this cycle.
- branch_taken  input  1  redirect request, single-cycle pulse.
- branch_target  input  ADDR_W  redirect address.

Behaviour:
- Clock and reset: single clock; rst is synchronous and active-high.
- Reset state: pc=RESET_PC; state=REQ; instr_out=0; instr_pc=0; redirect_pend=0.
- Reset outputs: mem_req=0 and instr_valid=0 in the rst cycle. mem_req rises in the first cycle after rst deasserts.
- Reset mid-transaction: the in-flight read is abandoned. Memory must tolerate mem_req dropping without ack when rst is high.

- States: REQ, HOLD, FLUSH.

- REQ:
  - mem_req=1, mem_addr=pc.
  - mem_ack & !branch_taken: instr_out<=mem_rdata; instr_pc<=pc; pc<=pc+1; go to HOLD.
  - mem_ack & branch_taken: drop the data; pc<=branch_target; stay in REQ.
  - !mem_ack & branch_taken: redirect_pend<=1; redirect_tgt<=branch_target; go to FLUSH. mem_addr is held at the old pc.
  - Otherwise: stay in REQ with the address held.

- FLUSH:
  - mem_req=1, mem_addr=old pc.
  - On mem_ack: discard data; pc<=redirect_tgt; redirect_pend<=0; go to REQ.
  - A further branch_taken while in FLUSH overwrites redirect_tgt (last redirect wins).

- HOLD:
  - mem_req=0; instr_valid = !branch_taken (combinational gate, so a wrong-path instruction is never accepted).
  - branch_taken: pc<=branch_target; go to REQ. This has priority over instr_ready.
  - instr_valid & instr_ready: go to REQ.
  - Otherwise: hold instr_out and instr_pc stable.

- instr_valid is low in REQ and FLUSH.
- Latency: ack in the first REQ cycle gives instr_valid in the next cycle. Peak throughput is 1 instruction per 2 cycles.
- PC arithmetic: pc+1 is modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 with no flag.
- Back-to-back branches in consecutive cycles: each is handled in the state current at that cycle; the last one wins.

Decomposition:
- fetch_pkg holds:
  - state encoding (REQ, HOLD, FLUSH)
  - RESET_PC default
  - INSTR_W/ADDR_W defaults
- Sub-module program_counter: pc register with load (branch/redirect), increment and sync reset.
- The FSM and output buffer stay in the top level.

Test Plan:
- Reset, memory acks every request in 1 cycle, instr_ready=1, mem returns 0x1000+addr -> instr_pc sequence 0,1,2,3 with instr_out 0x1000..0x1003; instr_valid high every other cycle.
- instr_ready=0 for 5 cycles while in HOLD -> instr_out/instr_pc held stable, mem_req=0; accept on cycle 6 -> next mem_addr=pc+1.
- branch_taken (target 0x0040) while in HOLD with instr_ready=1 -> instr_valid=0 that cycle, no accept; next mem_addr=0x0040.
- branch_taken (target 0x0080) during a 4-cycle-latency read of 0x0005 -> mem_addr held 0x0005 until ack, data discarded, instr_valid never asserted for it; next mem_addr=0x0080.
- pc=0xFFFF fetch -> instr_pc=0xFFFF; next mem_addr=0x0000.
- rst asserted during a pending read and in HOLD -> next cycle mem_req=0, instr_valid=0; after release mem_addr=RESET_PC.
